// File: rtl/mcp4922_scheduler_if.sv
// Update-request and DAC pin bundle for mcp4922_scheduler.
// master = signal-generation side, slave = the scheduler itself.
interface mcp4922_scheduler_if;
  logic [11:0] i_dataA;
  logic        i_strobeA;
  logic [11:0] i_dataB;
  logic        i_strobeB;
  logic        o_pendA;
  logic        o_pendB;
  logic        o_busy;
  logic        o_doneA;
  logic        o_doneB;
  logic        o_SPICLK;
  logic        o_MOSI;
  logic        o_CS;
  logic        o_LDAC;

  modport master (
    output i_dataA, i_strobeA, i_dataB, i_strobeB,
    input  o_pendA, o_pendB, o_busy, o_doneA, o_doneB,
    input  o_SPICLK, o_MOSI, o_CS, o_LDAC
  );

  modport slave (
    input  i_dataA, i_strobeA, i_dataB, i_strobeB,
    output o_pendA, o_pendB, o_busy, o_doneA, o_doneB,
    output o_SPICLK, o_MOSI, o_CS, o_LDAC
  );
endinterface

// File: rtl/mcp4922_scheduler.sv
// Coalescing round-robin A/B update scheduler driving an MCP4922 over SPI mode 0.
// Define MCP4922_SYNC_LDAC_EN to latch both channels together with one LDAC pulse.
module mcp4922_scheduler #(
  parameter int CLKDIV    = 4,
  parameter int CS_GAP    = 2,
  parameter bit REFBUFFER = 1'b1,
  parameter bit GAINONE   = 1'b1
) (
  input logic CLK,
  input logic RST,
  mcp4922_scheduler_if.slave bus
);

  localparam int DIV_W = $clog2(CLKDIV + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

`ifdef MCP4922_SYNC_LDAC_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, LDAC} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

  state_t state, state_nxt;

  logic [11:0]      hold_a, hold_b;
  logic             pend_a, pend_b, last_b, cur_b;
  logic [15:0]      shreg;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             sck, cs, done_a, done_b;
  logic             sel_a, sel_b, half_tick, last_fall, gap_end;

  // B wins only when A is idle or A was the channel served last.
  assign sel_b     = pend_b && (!pend_a || !last_b);
  assign sel_a     = pend_a && !sel_b;
  assign half_tick = (div_cnt == DIV_LAST);
  assign last_fall = (state == SHIFT) && half_tick && sck && (bit_cnt == 5'd15);
  assign gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pend_a || pend_b) state_nxt = SHIFT;
      SHIFT: if (last_fall) state_nxt = GAP;
`ifdef MCP4922_SYNC_LDAC_EN
      GAP:   if (gap_end) state_nxt = (pend_a || pend_b) ? IDLE : LDAC;
      LDAC:  if (half_tick) state_nxt = IDLE;
`else
      GAP:   if (gap_end) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MCP4922_SYNC_LDAC_EN
  logic ldac;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_a  <= '0;
      hold_b  <= '0;
      pend_a  <= 1'b0;
      pend_b  <= 1'b0;
      last_b  <= 1'b1;
      cur_b   <= 1'b0;
      cs      <= 1'b1;
      sck     <= 1'b0;
      done_a  <= 1'b0;
      done_b  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
`ifdef MCP4922_SYNC_LDAC_EN
      ldac    <= 1'b1;
`endif
    end else begin
      done_a <= 1'b0;
      done_b <= 1'b0;
      if (bus.i_strobeA) hold_a <= bus.i_dataA;
      if (bus.i_strobeB) hold_b <= bus.i_dataB;
      // A strobe landing in the selection cycle keeps its pend flag set.
      pend_a  <= bus.i_strobeA || (pend_a && !(state == IDLE && sel_a));
      pend_b  <= bus.i_strobeB || (pend_b && !(state == IDLE && sel_b));
      div_cnt <= (state != state_nxt || half_tick) ? '0 : div_cnt + 1'b1;
      case (state)
        IDLE: if (pend_a || pend_b) begin
          shreg   <= {sel_b, REFBUFFER, GAINONE, 1'b1, sel_b ? hold_b : hold_a};
          last_b  <= sel_b;
          cur_b   <= sel_b;
          cs      <= 1'b0;
          bit_cnt <= '0;
        end
        SHIFT: if (half_tick) begin
          sck <= !sck;
          if (sck) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + 5'd1;
          end
          if (last_fall) begin
            cs      <= 1'b1;
            done_a  <= !cur_b;
            done_b  <= cur_b;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
`ifdef MCP4922_SYNC_LDAC_EN
          if (gap_end && !pend_a && !pend_b) ldac <= 1'b0;
`endif
        end
`ifdef MCP4922_SYNC_LDAC_EN
        LDAC: if (half_tick) ldac <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifdef MCP4922_SYNC_LDAC_EN
  assign bus.o_LDAC = ldac;
`else
  assign bus.o_LDAC = 1'b0;
`endif

  assign bus.o_pendA  = pend_a;
  assign bus.o_pendB  = pend_b;
  assign bus.o_busy   = (state != IDLE);
  assign bus.o_doneA  = done_a;
  assign bus.o_doneB  = done_b;
  assign bus.o_SPICLK = sck;
  assign bus.o_MOSI   = (state == SHIFT) && shreg[15];
  assign bus.o_CS     = cs;

endmodule

// File: tb/tb_mcp4922_scheduler.sv
// Bench for mcp4922_scheduler: SPI frames are decoded from the pins and compared
// against directed vectors and a frame-level scheduling model.
module tb_mcp4922_scheduler;

  localparam int CLKDIV = 2;
  localparam int CS_GAP = 2;
`ifdef MCP4922_SYNC_LDAC_EN
  localparam logic LDAC_IDLE = 1'b1;
`else
  localparam logic LDAC_IDLE = 1'b0;
`endif

  logic CLK;
  logic RST;
  mcp4922_scheduler_if bus ();

  mcp4922_scheduler #(.CLKDIV(CLKDIV), .CS_GAP(CS_GAP), .REFBUFFER(1'b1), .GAINONE(1'b1)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Pin-level monitor: decodes frames, timing and done/LDAC pulses.
  logic [15:0] frames_q[$];
  int          fall_q[$];
  int          rise_q[$];
  int          ldac_fall_q[$];
  int          ldac_len_q[$];
  int          done_cnt = 0;
  logic [15:0] word;
  int          bits, first_rise, fall_cyc, ldac_start;
  bit          in_frame = 0;
  logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_ldac = 1'b0;

  always @(posedge CLK) begin
    #1;
    if (RST) begin
      in_frame = 0;
    end else begin
      if (prev_cs && !bus.o_CS) begin
        in_frame = 1; word = '0; bits = 0; first_rise = -1;
        fall_cyc = cyc; fall_q.push_back(cyc);
      end
      if (in_frame && !prev_sck && bus.o_SPICLK) begin
        word = {word[14:0], bus.o_MOSI};
        bits++;
        if (first_rise < 0) first_rise = cyc;
      end
      if (in_frame && !prev_cs && bus.o_CS) begin
        in_frame = 0;
        chk("frame_bits", bits, 16);
        chk("frame_len", cyc - fall_cyc, 32 * CLKDIV);
        chk("first_sck_rise", first_rise - fall_cyc, CLKDIV);
        chk("sck_low_at_end", bus.o_SPICLK, 1'b0);
        chk("doneA_pulse", bus.o_doneA, !word[15]);
        chk("doneB_pulse", bus.o_doneB, word[15]);
        chk("ldac_during_frame", prev_ldac, LDAC_IDLE);
        frames_q.push_back(word);
        rise_q.push_back(cyc);
      end
      if (prev_ldac && !bus.o_LDAC) begin
        ldac_start = cyc; ldac_fall_q.push_back(cyc);
      end
      if (!prev_ldac && bus.o_LDAC) ldac_len_q.push_back(cyc - ldac_start);
      if (bus.o_doneA || bus.o_doneB) done_cnt++;
    end
    prev_cs = bus.o_CS; prev_sck = bus.o_SPICLK; prev_ldac = bus.o_LDAC;
  end

  task automatic clear_mon();
    frames_q.delete(); fall_q.delete(); rise_q.delete();
    ldac_fall_q.delete(); ldac_len_q.delete();
  endtask

  task automatic drive(input logic [1:0] m, input logic [11:0] a, input logic [11:0] b);
    @(negedge CLK);
    bus.i_strobeA = m[0]; bus.i_strobeB = m[1];
    bus.i_dataA = a; bus.i_dataB = b;
  endtask

  task automatic release_strobes();
    @(negedge CLK);
    bus.i_strobeA = 1'b0; bus.i_strobeB = 1'b0;
  endtask

  task automatic wait_cs_low();
    int n = 0;
    while (bus.o_CS && n < 500) begin @(negedge CLK); n++; end
    chk("cs_fall_timeout", bus.o_CS, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.o_busy || bus.o_pendA || bus.o_pendB) && n < 2000) begin @(negedge CLK); n++; end
    chk("idle_timeout", {bus.o_busy, bus.o_pendA, bus.o_pendB}, 3'b000);
  endtask

  typedef struct {
    logic [1:0]  mask;
    logic [11:0] a, b;
    int          nfr;
    logic [15:0] f0, f1;
  } vec_t;

  vec_t vecs[6];

  // Frame-level reference model
  logic [11:0] mh[2];
  bit          mp[2];
  bit          m_last_b;
  logic [15:0] exp_q[$];

  task automatic serve();
    int c;
    if (mp[0] && mp[1]) c = m_last_b ? 0 : 1;
    else if (mp[0])     c = 0;
    else                c = 1;
    exp_q.push_back({c[0], 3'b111, mh[c]});
    mp[c] = 0;
    m_last_b = c[0];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    RST = 1'b1;
    bus.i_strobeA = 1'b0; bus.i_strobeB = 1'b0;
    bus.i_dataA = '0; bus.i_dataB = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk("rst_cs", bus.o_CS, 1'b1);
    chk("rst_sck", bus.o_SPICLK, 1'b0);
    chk("rst_mosi", bus.o_MOSI, 1'b0);
    chk("rst_busy", bus.o_busy, 1'b0);
    chk("rst_pend", {bus.o_pendA, bus.o_pendB}, 2'b00);
    chk("rst_done", {bus.o_doneA, bus.o_doneB}, 2'b00);
    chk("rst_ldac", bus.o_LDAC, LDAC_IDLE);

    // Expected frames follow the alternation rule starting from lastB=1.
    vecs[0] = '{2'b11, 12'h100, 12'h123, 2, 16'h7100, 16'hF123};
    vecs[1] = '{2'b11, 12'h456, 12'h789, 2, 16'h7456, 16'hF789};
    vecs[2] = '{2'b01, 12'h800, 12'h000, 1, 16'h7800, 16'h0000};
    vecs[3] = '{2'b11, 12'hFFF, 12'h000, 2, 16'hF000, 16'h7FFF};
    vecs[4] = '{2'b10, 12'h000, 12'h5A5, 1, 16'hF5A5, 16'h0000};
    vecs[5] = '{2'b11, 12'h001, 12'hFFE, 2, 16'h7001, 16'hFFFE};

    for (int i = 0; i < 6; i++) begin
      clear_mon();
      drive(vecs[i].mask, vecs[i].a, vecs[i].b);
      release_strobes();
      chk("pend_t1", {bus.o_pendB, bus.o_pendA}, vecs[i].mask);
      chk("cs_high_t1", bus.o_CS, 1'b1);
      @(negedge CLK);
      chk("cs_low_t2", bus.o_CS, 1'b0);
      chk("busy_t2", bus.o_busy, 1'b1);
      wait_idle();
      chk("vec_nframes", frames_q.size(), vecs[i].nfr);
      if (frames_q.size() > 0) chk("vec_frame0", frames_q[0], vecs[i].f0);
      if (vecs[i].nfr == 2 && frames_q.size() == 2) begin
        chk("vec_frame1", frames_q[1], vecs[i].f1);
        chk("b2b_gap", fall_q[1] - rise_q[0], CS_GAP + 1);
      end
`ifdef MCP4922_SYNC_LDAC_EN
      chk("ldac_pulses", ldac_len_q.size(), 1);
      if (ldac_len_q.size() == 1 && rise_q.size() > 0) begin
        chk("ldac_len", ldac_len_q[0], CLKDIV);
        chk("ldac_after_gap", ldac_fall_q[0] - rise_q[rise_q.size() - 1], CS_GAP);
      end
`endif
      chk("pend_after", {bus.o_pendA, bus.o_pendB}, 2'b00);
    end

    // Coalescing: three B strobes during an A frame give one B frame.
    clear_mon();
    drive(2'b01, 12'h3C3, 12'h000);
    release_strobes();
    wait_cs_low();
    repeat (10) @(negedge CLK);
    drive(2'b10, 12'h000, 12'h001);
    drive(2'b10, 12'h000, 12'h002);
    drive(2'b10, 12'h000, 12'h003);
    release_strobes();
    wait_idle();
    chk("coal_nframes", frames_q.size(), 2);
    if (frames_q.size() == 2) begin
      chk("coal_frame0", frames_q[0], 16'h73C3);
      chk("coal_frame1", frames_q[1], 16'hF003);
    end

    // Strobe in the selection cycle: old value sent, new value sent next.
    clear_mon();
    drive(2'b01, 12'h111, 12'h000);
    drive(2'b01, 12'hABC, 12'h000);
    release_strobes();
    chk("selcyc_cs_low", bus.o_CS, 1'b0);
    chk("selcyc_pendA", bus.o_pendA, 1'b1);
    wait_idle();
    chk("selcyc_nframes", frames_q.size(), 2);
    if (frames_q.size() == 2) begin
      chk("selcyc_frame0", frames_q[0], 16'h7111);
      chk("selcyc_frame1", frames_q[1], 16'h7ABC);
    end

    // Reset mid-frame with B pending and a strobe during the reset cycle.
    clear_mon();
    d0 = done_cnt;
    drive(2'b01, 12'h222, 12'h000);
    release_strobes();
    wait_cs_low();
    repeat (17) @(negedge CLK);
    drive(2'b10, 12'h000, 12'h555);
    @(negedge CLK);
    chk("abort_pendB_before", bus.o_pendB, 1'b1);
    RST = 1'b1; bus.i_strobeB = 1'b0; bus.i_strobeA = 1'b1; bus.i_dataA = 12'h777;
    @(negedge CLK);
    RST = 1'b0; bus.i_strobeA = 1'b0;
    chk("abort_cs", bus.o_CS, 1'b1);
    chk("abort_sck", bus.o_SPICLK, 1'b0);
    chk("abort_pend", {bus.o_pendA, bus.o_pendB}, 2'b00);
    chk("abort_busy", bus.o_busy, 1'b0);
    repeat (150) @(negedge CLK);
    chk("abort_no_frame", frames_q.size() + rise_q.size(), 0);
    chk("abort_no_refall", fall_q.size(), 1);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", {bus.o_busy, bus.o_pendA, bus.o_pendB}, 3'b000);

    // Randomized bursts against the frame-level model.
    m_last_b = 1'b1;
    mp[0] = 0; mp[1] = 0; mh[0] = '0; mh[1] = '0;
    for (int it = 0; it < 25; it++) begin
      logic [1:0]  m;
      logic [11:0] a, b;
      int          n;
      clear_mon();
      exp_q.delete();
      m = 2'($urandom_range(1, 3));
      a = 12'($urandom); b = 12'($urandom);
      drive(m, a, b);
      release_strobes();
      if (m[0]) begin mh[0] = a; mp[0] = 1; end
      if (m[1]) begin mh[1] = b; mp[1] = 1; end
      serve();
      wait_cs_low();
      repeat ($urandom_range(3, 40)) @(negedge CLK);
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        m = 2'($urandom_range(1, 3));
        a = 12'($urandom); b = 12'($urandom);
        drive(m, a, b);
        if (m[0]) begin mh[0] = a; mp[0] = 1; end
        if (m[1]) begin mh[1] = b; mp[1] = 1; end
      end
      if (n > 0) release_strobes();
      while (mp[0] || mp[1]) serve();
      wait_idle();
      chk("rand_nframes", frames_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < frames_q.size(); k++)
        chk("rand_frame", frames_q[k], exp_q[k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
